// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings and PC-unit defaults.
package cpu_pkg;

  // Next-PC select encodings, shared with PC_MUX and the control unit
  typedef enum logic [1:0] {
    PC_SRC_PLUS1  = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_RET    = 2'b11
  } pc_src_e;

  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned RAS_DEPTH_DEF = 4;
  localparam int unsigned RESET_PC_DEF  = 0;
  localparam int unsigned INT_PC_DEF    = 1;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control-side bus of the PC fetch unit: next-PC controls in, PC and RAS status out.
interface pc_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
);
  localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

  logic              pc_write;
  logic [1:0]        pc_src;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] jump_addr;
  logic              call;
  logic [ADDR_W-1:0] ret_addr;
  logic              int_req;
  logic              ras_clr;

  logic [ADDR_W-1:0] pc_current;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] ras_top;
  logic [CntW-1:0]   ras_count;
  logic              ras_overflow;
  logic              ras_underflow;
  logic              int_ack;

  // Control unit side
  modport master (
    output pc_write, pc_src, branch_addr, jump_addr, call, ret_addr, int_req, ras_clr,
    input  pc_current, pc_plus1, ras_top, ras_count, ras_overflow, ras_underflow, int_ack
  );

  // Fetch unit side
  modport slave (
    input  pc_write, pc_src, branch_addr, jump_addr, call, ret_addr, int_req, ras_clr,
    output pc_current, pc_plus1, ras_top, ras_count, ras_overflow, ras_underflow, int_ack
  );

endinterface

// File: rtl/pc_fetch_unit_ras.sv
// Circular return-address stack. Push and pop together replace the top entry (swap);
// on an empty stack the swap degenerates into a push and flags underflow.
module ras_stack #(
  parameter int unsigned AddrW = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_i,
  input  logic [AddrW-1:0] wdata_i,
  output logic [AddrW-1:0] top_o,
  output logic [CntW-1:0]  count_o,
  output logic             ovf_o,
  output logic             unf_o
);

  logic [AddrW-1:0] mem_q [Depth];
  // ptr_q is the next free slot; the top entry sits one below it
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [PtrW-1:0]  waddr;
  logic [PtrW-1:0]  top_idx;
  logic             empty;
  logic             full;

  assign top_idx = ptr_q - PtrW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));

  // Next-state for pointer, count and sticky flags; clear beats any push/pop
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = ptr_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (push_i && pop_i) begin
      we = 1'b1;
      if (empty) begin
        waddr = ptr_q;
        ptr_d = ptr_q + PtrW'(1);
        cnt_d = CntW'(1);
        unf_d = 1'b1;
      end else begin
        waddr = top_idx;
      end
    end else if (push_i) begin
      // When full, ptr_q points at the oldest entry, so this overwrites it
      we    = 1'b1;
      waddr = ptr_q;
      ptr_d = ptr_q + PtrW'(1);
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop_i) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  // Entry storage, cleared on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata_i;
    end
  end

  // Pointer, count and sticky flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign top_o   = empty ? '0 : mem_q[top_idx];
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with next-PC mux, interrupt gating and a hardware return-address stack.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int unsigned RESET_PC  = RESET_PC_DEF,
  parameter int unsigned INT_PC    = INT_PC_DEF
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              int_ack_q;
  logic [ADDR_W-1:0] pc_plus1;
  logic              int_take;
  logic              push;
  logic              pop;
  logic              clr;
  pc_src_e           src;
  logic [ADDR_W-1:0] ras_top;
  logic [CntW-1:0]   ras_count;
  logic              ras_ovf;
  logic              ras_unf;

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign src      = pc_src_e'(bus.pc_src);
  // Interrupts only slip in on a plain sequential step, never over a control transfer
  assign int_take = bus.pc_write & bus.int_req & (src == PC_SRC_PLUS1) & ~bus.call;
  assign clr      = bus.pc_write & bus.ras_clr;

  // Next-PC selection and RAS push/pop requests
  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    if (bus.pc_write) begin
      if (int_take) begin
        pc_d = ADDR_W'(INT_PC);
        push = 1'b1;
      end else begin
        unique case (src)
          PC_SRC_PLUS1:  pc_d = pc_plus1;
          PC_SRC_BRANCH: pc_d = bus.branch_addr;
          PC_SRC_JUMP: begin
            pc_d = bus.jump_addr;
            push = bus.call;
          end
          PC_SRC_RET: begin
            // call together with return swaps the top entry for pc_plus1
            pop  = 1'b1;
            push = bus.call;
            pc_d = (ras_count != '0) ? ras_top : bus.ret_addr;
          end
          default: pc_d = pc_q;
        endcase
      end
    end
  end

  // PC register and one-cycle interrupt acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= ADDR_W'(RESET_PC);
      int_ack_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      int_ack_q <= int_take;
    end
  end

  ras_stack #(
    .AddrW (ADDR_W),
    .Depth (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (clr),
    .wdata_i (pc_plus1),
    .top_o   (ras_top),
    .count_o (ras_count),
    .ovf_o   (ras_ovf),
    .unf_o   (ras_unf)
  );

  assign bus.pc_current    = pc_q;
  assign bus.pc_plus1      = pc_plus1;
  assign bus.ras_top       = ras_top;
  assign bus.ras_count     = ras_count;
  assign bus.ras_overflow  = ras_ovf;
  assign bus.ras_underflow = ras_unf;
  assign bus.int_ack       = int_ack_q;

endmodule
